rvfi_check_ctrl: RTL and testbench

Sequencer for single-instruction RVFI checkers such as the PC-forward check. It owns the checker's reset window, counts cycles, and watches the retirement stream for a configured target instruction order. It fires the one-cycle `check` strobe when that instruction retires on the selected channel, and flags whether its predecessor was retired. It sits between the core wrapper's RVFI bus and one checker instance, and drives that checker's `reset` and `check` inputs.

---
 rtl/rvfi_check_ctrl.sv | 134 +++++++++++++
 tb/tb_rvfi_check_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/rvfi_check_ctrl.sv
// rvfi_check_ctrl: sequencer for a single-instruction RVFI checker.
// Holds the checker in reset for a fixed window, then counts RUN cycles and
// watches the retirement stream for the target instruction order. Fires a
// one-cycle check strobe when the target retires on the selected channel and
// reports whether its predecessor (order target-1) has already retired.
module rvfi_check_ctrl #(
    parameter int          NRET       = 1,
    parameter int          CHANNEL    = 0,
    parameter int          RST_CYCLES = 1,
    parameter int          MIN_CYCLE  = 0,
    parameter logic [15:0] MAX_CYCLE  = 16'hffff
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic [NRET-1:0]    rvfi_valid,
    input  logic [64*NRET-1:0] rvfi_order,
    input  logic [63:0]        target_order,
    output logic               check_reset,
    output logic               check,
    output logic               pred_seen,
    output logic               done,
    output logic               timeout,
    output logic [15:0]        cycle
);

    typedef enum logic [1:0] {
        ST_RST,
        ST_RUN,
        ST_DONE,
        ST_TIMEOUT
    } state_t;

    state_t      state_q,   state_d;
    logic [31:0] rst_cnt_q, rst_cnt_d;
    logic [15:0] cycle_q,   cycle_d;
    logic        pred_q,    pred_d;
    logic [63:0] tgt_q,     tgt_d;

    logic        in_run;
    logic        tgt_nonzero;
    logic        min_ok;
    logic        hit;
    logic        pred_hit;
    logic        pred_lo;
    logic [63:0] tgt_m1;

    assign in_run      = (state_q == ST_RUN);
    assign tgt_nonzero = (tgt_q != 64'd0);
    assign tgt_m1      = tgt_q - 64'd1;
    assign min_ok      = ($signed({16'd0, cycle_q}) >= MIN_CYCLE);

    // Match the target on the checked channel and the predecessor on any
    // channel; a predecessor on a lower channel counts in the same cycle
    // because lower channels retire earlier in program order.
    always_comb begin
        logic ph;
        logic pl;
        ph = 1'b0;
        pl = 1'b0;
        for (int i = 0; i < NRET; i++) begin
            if (rvfi_valid[i] && (rvfi_order[64*i +: 64] == tgt_m1)) begin
                ph = 1'b1;
                if (i < CHANNEL) begin
                    pl = 1'b1;
                end
            end
        end
        hit      = in_run && rvfi_valid[CHANNEL] &&
                   (rvfi_order[64*CHANNEL +: 64] == tgt_q) && min_ok;
        pred_hit = in_run && tgt_nonzero && ph;
        pred_lo  = in_run && tgt_nonzero && pl;
    end

    // Next-state logic for the sequencer, the cycle counter and sticky state.
    always_comb begin
        state_d   = state_q;
        rst_cnt_d = rst_cnt_q;
        cycle_d   = cycle_q;
        pred_d    = pred_q;
        tgt_d     = tgt_q;
        case (state_q)
            ST_RST: begin
                if (rst_cnt_q == 32'(RST_CYCLES - 1)) begin
                    rst_cnt_d = 32'd0;
                    tgt_d     = target_order;
                    state_d   = ST_RUN;
                end else begin
                    rst_cnt_d = rst_cnt_q + 32'd1;
                end
            end
            ST_RUN: begin
                if (cycle_q < MAX_CYCLE) begin
                    cycle_d = cycle_q + 16'd1;
                end
                if (pred_hit) begin
                    pred_d = 1'b1;
                end
                if (hit) begin
                    state_d = ST_DONE;
                end else if (cycle_q == MAX_CYCLE) begin
                    state_d = ST_TIMEOUT;
                end
            end
            default: begin
                state_d = state_q;
            end
        endcase
    end

    // State registers; reset clears everything and reopens the reset window.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ST_RST;
            rst_cnt_q <= 32'd0;
            cycle_q   <= 16'd0;
            pred_q    <= 1'b0;
            tgt_q     <= 64'd0;
        end else begin
            state_q   <= state_d;
            rst_cnt_q <= rst_cnt_d;
            cycle_q   <= cycle_d;
            pred_q    <= pred_d;
            tgt_q     <= tgt_d;
        end
    end

    assign check_reset = (state_q == ST_RST);
    assign check       = hit;
    assign pred_seen   = tgt_nonzero && (pred_q || pred_lo);
    assign done        = (state_q == ST_DONE);
    assign timeout     = (state_q == ST_TIMEOUT);
    assign cycle       = cycle_q;

endmodule

// File: tb/tb_rvfi_check_ctrl.sv
// Directed bench for rvfi_check_ctrl: three instances cover the single-channel
// flow, dual-channel retirement and the MIN/MAX cycle window.
`timescale 1ns/1ps
module tb_rvfi_check_ctrl;

    logic clock;

    // Instance 1: NRET=1, RST_CYCLES=2
    logic        rstn1;
    logic [0:0]  valid1;
    logic [63:0] order1, tgt1;
    logic        creset1, check1, pred1, done1, to1;
    logic [15:0] cyc1;

    // Instance 2: NRET=2, CHANNEL=1, RST_CYCLES=1
    logic         rstn2;
    logic [1:0]   valid2;
    logic [127:0] order2;
    logic [63:0]  tgt2;
    logic         creset2, check2, pred2, done2, to2;
    logic [15:0]  cyc2;

    // Instance 3: MIN_CYCLE=3, MAX_CYCLE=10
    logic        rstn3;
    logic [0:0]  valid3;
    logic [63:0] order3, tgt3;
    logic        creset3, check3, pred3, done3, to3;
    logic [15:0] cyc3;

    int n_compared;
    int n_mismatched;

    rvfi_check_ctrl #(.NRET(1), .CHANNEL(0), .RST_CYCLES(2)) u1 (
        .clock(clock), .resetn(rstn1), .rvfi_valid(valid1), .rvfi_order(order1),
        .target_order(tgt1), .check_reset(creset1), .check(check1),
        .pred_seen(pred1), .done(done1), .timeout(to1), .cycle(cyc1)
    );

    rvfi_check_ctrl #(.NRET(2), .CHANNEL(1), .RST_CYCLES(1)) u2 (
        .clock(clock), .resetn(rstn2), .rvfi_valid(valid2), .rvfi_order(order2),
        .target_order(tgt2), .check_reset(creset2), .check(check2),
        .pred_seen(pred2), .done(done2), .timeout(to2), .cycle(cyc2)
    );

    rvfi_check_ctrl #(.NRET(1), .CHANNEL(0), .RST_CYCLES(1), .MIN_CYCLE(3),
                      .MAX_CYCLE(16'd10)) u3 (
        .clock(clock), .resetn(rstn3), .rvfi_valid(valid3), .rvfi_order(order3),
        .target_order(tgt3), .check_reset(creset3), .check(check3),
        .pred_seen(pred3), .done(done3), .timeout(to3), .cycle(cyc3)
    );

    // Free-running clock, 10 ns period.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Safety net so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed still running, expected finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string tag, input logic [63:0] observed,
                                input logic [63:0] expected);
        n_compared++;
        if (observed !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Main directed sequence; inputs change on the falling edge and outputs
    // are sampled 1 ns later.
    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        rstn1 = 1'b0; valid1 = '0; order1 = '0; tgt1 = '0;
        rstn2 = 1'b0; valid2 = '0; order2 = '0; tgt2 = '0;
        rstn3 = 1'b0; valid3 = '0; order3 = '0; tgt3 = '0;

        repeat (2) @(negedge clock);
        #1;
        check_output("rst_check_reset", 64'(creset1), 64'd1);
        check_output("rst_check",       64'(check1),  64'd0);
        check_output("rst_pred_seen",   64'(pred1),   64'd0);
        check_output("rst_done",        64'(done1),   64'd0);
        check_output("rst_timeout",     64'(to1),     64'd0);
        check_output("rst_cycle",       64'(cyc1),    64'd0);

        // Single channel, target 5, orders 0..7 one per cycle.
        @(negedge clock); tgt1 = 64'd5; rstn1 = 1'b1; #1;
        check_output("t1_creset_0", 64'(creset1), 64'd1);
        @(negedge clock); #1;
        check_output("t1_creset_1", 64'(creset1), 64'd1);
        for (int k = 0; k < 8; k++) begin
            @(negedge clock);
            valid1 = 1'b1;
            order1 = 64'(k);
            if (k == 1) tgt1 = 64'd6;
            #1;
            check_output("t1_creset", 64'(creset1), 64'd0);
            check_output("t1_check",  64'(check1),  64'(k == 5));
            check_output("t1_pred",   64'(pred1),   64'(k >= 5));
            check_output("t1_done",   64'(done1),   64'(k >= 6));
            check_output("t1_cycle",  64'(cyc1),    64'((k <= 6) ? k : 6));
        end
        valid1 = '0;

        // Target 0 retires in the first RUN cycle; no wrap-around predecessor.
        @(negedge clock); rstn1 = 1'b0; #1;
        @(negedge clock); tgt1 = 64'd0; rstn1 = 1'b1;
        repeat (2) @(negedge clock);
        valid1 = 1'b1; order1 = 64'd0; #1;
        check_output("t0_cycle", 64'(cyc1),  64'd0);
        check_output("t0_check", 64'(check1), 64'd1);
        check_output("t0_pred",  64'(pred1),  64'd0);
        @(negedge clock); valid1 = '0; #1;
        check_output("t0_done", 64'(done1), 64'd1);

        // Reset asserted mid-RUN at cycle 4 after the predecessor retired.
        @(negedge clock); rstn1 = 1'b0; #1;
        @(negedge clock); tgt1 = 64'd100; rstn1 = 1'b1;
        repeat (1) @(negedge clock);
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            valid1 = 1'(k == 2);
            order1 = 64'd99;
            #1;
            check_output("mr_cycle", 64'(cyc1), 64'(k));
        end
        check_output("mr_pred_before", 64'(pred1), 64'd1);
        valid1 = '0;
        rstn1  = 1'b0; #1;
        check_output("mr_creset_async", 64'(creset1), 64'd1);
        check_output("mr_cycle_clr",    64'(cyc1),    64'd0);
        check_output("mr_pred_clr",     64'(pred1),   64'd0);
        @(negedge clock); rstn1 = 1'b1; #1;
        check_output("mr_creset_0", 64'(creset1), 64'd1);
        @(negedge clock); #1;
        check_output("mr_creset_1", 64'(creset1), 64'd1);
        @(negedge clock); #1;
        check_output("mr_creset_2", 64'(creset1), 64'd0);
        check_output("mr_cycle_0",  64'(cyc1),    64'd0);
        check_output("mr_pred_0",   64'(pred1),   64'd0);

        // Dual retirement: order 3 on ch0 and order 4 on ch1 together.
        @(negedge clock); tgt2 = 64'd4; rstn2 = 1'b1; #1;
        check_output("d_creset", 64'(creset2), 64'd1);
        @(negedge clock);
        valid2 = 2'b11; order2 = {64'd4, 64'd3}; #1;
        check_output("d_creset_low", 64'(creset2), 64'd0);
        check_output("d_check",      64'(check2),  64'd1);
        check_output("d_pred",       64'(pred2),   64'd1);
        @(negedge clock); valid2 = '0; #1;
        check_output("d_done",    64'(done2),  64'd1);
        check_output("d_check_1", 64'(check2), 64'd0);

        // Dual retirement with target 0: all-ones on ch0 is not a predecessor.
        @(negedge clock); rstn2 = 1'b0; #1;
        @(negedge clock); tgt2 = 64'd0; rstn2 = 1'b1;
        @(negedge clock);
        valid2 = 2'b11; order2 = {64'd0, 64'hFFFF_FFFF_FFFF_FFFF}; #1;
        check_output("dz_check", 64'(check2), 64'd1);
        check_output("dz_pred",  64'(pred2),  64'd0);
        valid2 = '0;

        // MIN_CYCLE=3: early target ignored, then timeout at MAX_CYCLE=10.
        @(negedge clock); tgt3 = 64'd7; rstn3 = 1'b1;
        for (int k = 0; k <= 10; k++) begin
            @(negedge clock);
            valid3 = 1'(k == 1);
            order3 = 64'd7;
            #1;
            check_output("to_cycle",   64'(cyc3),  64'(k));
            check_output("to_check",   64'(check3), 64'd0);
            check_output("to_timeout", 64'(to3),    64'd0);
        end
        @(negedge clock); valid3 = 1'b1; #1;
        check_output("to_timeout_set", 64'(to3),    64'd1);
        check_output("to_cycle_sat",   64'(cyc3),   64'd10);
        check_output("to_check_after", 64'(check3), 64'd0);
        check_output("to_done",        64'(done3),  64'd0);
        valid3 = '0;

        // Target at exactly MIN_CYCLE fires.
        @(negedge clock); rstn3 = 1'b0; #1;
        @(negedge clock); rstn3 = 1'b1;
        for (int k = 0; k <= 3; k++) begin
            @(negedge clock);
            valid3 = 1'(k == 3);
            #1;
            check_output("min_check", 64'(check3), 64'(k == 3));
        end
        @(negedge clock); valid3 = '0; #1;
        check_output("min_done", 64'(done3), 64'd1);

        // Target at exactly MAX_CYCLE: hit beats timeout.
        @(negedge clock); rstn3 = 1'b0; #1;
        @(negedge clock); rstn3 = 1'b1;
        for (int k = 0; k <= 10; k++) begin
            @(negedge clock);
            valid3 = 1'(k == 10);
            #1;
            check_output("max_check", 64'(check3), 64'(k == 10));
        end
        @(negedge clock); valid3 = '0; #1;
        check_output("max_done",    64'(done3), 64'd1);
        check_output("max_timeout", 64'(to3),   64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
